// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared chunk-width derivation and parameter legality check for pipe_adder_n
package pipe_adder_pkg;
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction
  function automatic bit widths_ok(input int width, input int stages);
    return stages >= 1 && width % stages == 0;
  endfunction
endpackage

// File: rtl/pipe_adder_stage.sv
// pipe_adder_stage: one CW-bit carry-chain chunk with carry, valid, skew (A/B') and deskew (sum) registers
//   en          pipeline advance; every register holds when low
//   v_in/v_q    stage valid in/out
//   c_in/c_q    carry from previous stage / carry out of this chunk
//   a_in,b_in   operands (B already conditioned for subtract), forwarded as a_q,b_q
//   s_in/s_q    partially assembled sum; this stage fills chunk K
module pipe_adder_stage #(
  parameter int WIDTH = 8,
  parameter int CW = 4,
  parameter int K = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             v_in,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] s_in,
  output logic             v_q,
  output logic             c_q,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] s_q
);
  logic [CW:0] r;
  assign r = {1'b0, a_in[K*CW +: CW]} + {1'b0, b_in[K*CW +: CW]} + {{CW{1'b0}}, c_in};
  // data only moves with a valid token so bubbles leave the last result untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      c_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
    end else if (en) begin
      v_q <= v_in;
      if (v_in) begin
        c_q <= r[CW];
        a_q <= a_in;
        b_q <= b_in;
        s_q <= s_in;
        s_q[K*CW +: CW] <= r[CW-1:0];
      end
    end
  end
endmodule

// File: rtl/pipe_adder_n.sv
// pipe_adder_n: pipelined WIDTH-bit add/subtract split into STAGES carry chunks with valid/ready backpressure
//   in_valid/in_ready    operand handshake; A, B, Cin, Sub sampled on transfer
//   out_valid/out_ready  result handshake; Sum, Cout, V, Z held until taken
//   Sub=1 computes A - B - Cin with Cout=1 meaning no borrow
module pipe_adder_n
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             V,
  output logic             Z
);
  localparam int CW = chunk_width(WIDTH, STAGES);
  if (!widths_ok(WIDTH, STAGES)) begin : g_bad
    $error("pipe_adder_n: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end
  logic             en;
  logic             v_w [STAGES+1];
  logic             c_w [STAGES+1];
  logic [WIDTH-1:0] a_w [STAGES+1];
  logic [WIDTH-1:0] b_w [STAGES+1];
  logic [WIDTH-1:0] s_w [STAGES+1];
  // the whole pipe advances unless a finished result is waiting on the consumer
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign v_w[0]   = in_valid;
  assign c_w[0]   = Sub ? ~Cin : Cin;
  assign a_w[0]   = A;
  assign b_w[0]   = Sub ? ~B : B;
  assign s_w[0]   = '0;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_adder_stage #(.WIDTH(WIDTH), .CW(CW), .K(k)) u_stage (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .v_in (v_w[k]),
      .c_in (c_w[k]),
      .a_in (a_w[k]),
      .b_in (b_w[k]),
      .s_in (s_w[k]),
      .v_q  (v_w[k+1]),
      .c_q  (c_w[k+1]),
      .a_q  (a_w[k+1]),
      .b_q  (b_w[k+1]),
      .s_q  (s_w[k+1])
    );
  end
  assign out_valid = v_w[STAGES];
  assign Sum       = s_w[STAGES];
  assign Cout      = c_w[STAGES];
  assign Z         = Sum == '0;
  // signed overflow: like-signed operands producing a result of the other sign
  assign V = (a_w[STAGES][WIDTH-1] == b_w[STAGES][WIDTH-1]) && (Sum[WIDTH-1] != a_w[STAGES][WIDTH-1]);
endmodule
